// File: rtl/rom_uart_loader.sv
// Boot loader: parses a framed program image from the UART byte stream
// and writes it word by word into the instruction ROM.
module rom_uart_loader #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          MAX_WORDS   = 512,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rom_we_o,
  output logic [31:0] rom_addr_o,
  output logic [31:0] rom_data_o,
  output logic        halt_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CSUM, ERR
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   widx_q, widx_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [23:0]   buf_q, buf_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          halt_q, halt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  logic          active;
  logic [15:0]   len;
  logic [15:0]   widx_inc;

  assign active   = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA) || (state_q == CSUM);
  assign len      = {rx_data_i, cnt_q[7:0]};
  assign widx_inc = widx_q + 16'd1;

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    buf_d   = buf_q;
    csum_d  = csum_q;
    tmr_d   = tmr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    halt_d  = halt_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;

    if (rx_valid_i || !active) begin
      tmr_d = '0;
    end else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
      tmr_d   = '0;
      state_d = ERR;
      err_d   = 1'b1;
      code_d  = 2'd3;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end

    if (rx_valid_i) begin
      unique case (state_q)
        IDLE, ERR: begin
          if (rx_data_i == MAGIC) begin
            state_d = LEN_LO;
            halt_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = 2'd0;
            csum_d  = '0;
            widx_d  = '0;
            bidx_d  = '0;
          end
        end
        LEN_LO: begin
          cnt_d[7:0] = rx_data_i;
          state_d    = LEN_HI;
        end
        LEN_HI: begin
          cnt_d[15:8] = rx_data_i;
          if (len == 16'd0 || len > 16'(MAX_WORDS)) begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = 2'd1;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          csum_d = csum_q + rx_data_i;
          bidx_d = bidx_q + 2'd1;
          buf_d  = {rx_data_i, buf_q[23:8]};
          if (bidx_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = ADDR_BASE + {14'd0, widx_q, 2'b00};
            data_d = {rx_data_i, buf_q};
            widx_d = widx_inc;
            if (widx_inc == cnt_q) state_d = CSUM;
          end
        end
        CSUM: begin
          if (rx_data_i == csum_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            halt_d  = 1'b0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = 2'd2;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      buf_q   <= '0;
      csum_q  <= '0;
      tmr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      buf_q   <= buf_d;
      csum_q  <= csum_d;
      tmr_q   <= tmr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign rom_we_o   = we_q;
  assign rom_addr_o = addr_q;
  assign rom_data_o = data_q;
  assign halt_o     = halt_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule

// File: tb/tb_rom_uart_loader.sv
// Directed bench for rom_uart_loader with a write scoreboard
// checking address, data and exact write cycle.
module tb_rom_uart_loader;

  localparam logic [31:0] ADDR_BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rom_we_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_o;
  logic        halt_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  rom_uart_loader #(
    .ADDR_BASE(ADDR_BASE),
    .MAX_WORDS(512),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_valid_i(rx_valid),
    .rx_data_i(rx_data),
    .rom_we_o(rom_we_o),
    .rom_addr_o(rom_addr_o),
    .rom_data_o(rom_data_o),
    .halt_o(halt_o),
    .done_o(done_o),
    .err_o(err_o),
    .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] c;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int tcount = 0;
  logic [7:0] fr[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rom_we_o === 1'b1) begin
      chk("we_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("we_addr", rom_addr_o, e.a);
        chk("we_data", rom_data_o, e.d);
        chk("we_cycle", 32'(tcount), e.c);
      end
    end
    chk("done_err_excl", 32'(done_o & err_o), 32'd0);
    @(posedge clk);
    #1;
    tcount++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b[$], input int gap,
                      input int nw);
    logic [31:0] w;
    int k;
    w = '0;
    for (int i = 0; i < b.size(); i++) begin
      put(b[i]);
      if (i >= 3 && i < 3 + 4 * nw) begin
        k = i - 3;
        w = {b[i], w[31:8]};
        if (k % 4 == 3)
          q.push_back('{a: ADDR_BASE + 32'(4 * (k / 4)),
                        d: w, c: 32'(tcount)});
      end
      if (i == 0) chk("halt_on_magic", 32'(halt_o), 32'd1);
      if (i + 1 < b.size()) idle(gap);
    end
  endtask

  task automatic chk_status(input string tag, input logic h,
                            input logic d, input logic e,
                            input logic [1:0] c);
    chk({tag, "_halt"}, 32'(halt_o), 32'(h));
    chk({tag, "_done"}, 32'(done_o), 32'(d));
    chk({tag, "_err"}, 32'(err_o), 32'(e));
    chk({tag, "_code"}, 32'(err_code_o), 32'(c));
    chk({tag, "_qempty"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    idle(3);
    chk("rst_we", 32'(rom_we_o), 32'd0);
    chk("rst_addr", rom_addr_o, 32'd0);
    chk("rst_data", rom_data_o, 32'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    idle(2);

    fr = '{8'hA5, 8'h02, 8'h00, 8'h97, 8'h11, 8'h00, 8'h10,
           8'h93, 8'h81, 8'h01, 8'h80, 8'h4D};
    send(fr, 2, 2);
    chk_status("good_gap", 1'b0, 1'b1, 1'b0, 2'd0);
    idle(3);

    send(fr, 0, 2);
    chk_status("good_b2b", 1'b0, 1'b1, 1'b0, 2'd0);
    idle(3);

    fr[11] = 8'h4E;
    send(fr, 1, 2);
    chk_status("bad_csum", 1'b1, 1'b0, 1'b1, 2'd2);
    idle(3);

    fr[11] = 8'h4D;
    send(fr, 0, 2);
    chk_status("recover", 1'b0, 1'b1, 1'b0, 2'd0);
    idle(2);

    fr = '{8'hA5, 8'h00, 8'h00};
    send(fr, 0, 0);
    idle(3);
    chk_status("len_zero", 1'b1, 1'b0, 1'b1, 2'd1);

    fr = '{8'hA5, 8'h01, 8'h02};
    send(fr, 1, 0);
    idle(3);
    chk_status("len_513", 1'b1, 1'b0, 1'b1, 2'd1);

    fr = '{8'hA5, 8'h02, 8'h00, 8'h97};
    send(fr, 0, 2);
    idle(15);
    chk("tmo_early_err", 32'(err_o), 32'd0);
    chk("tmo_early_halt", 32'(halt_o), 32'd1);
    idle(1);
    chk_status("tmo", 1'b1, 1'b0, 1'b1, 2'd3);
    idle(2);

    fr = '{8'hA5, 8'h02, 8'h00, 8'h97, 8'h11, 8'h00, 8'h10, 8'h93};
    send(fr, 0, 2);
    rst = 1'b1;
    tick();
    chk("midrst_we", 32'(rom_we_o), 32'd0);
    chk("midrst_addr", rom_addr_o, 32'd0);
    chk("midrst_data", rom_data_o, 32'd0);
    chk_status("midrst", 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    idle(1);

    put(8'h00);
    put(8'hFF);
    idle(1);
    put(8'h12);
    idle(20);
    chk_status("noise", 1'b0, 1'b0, 1'b0, 2'd0);

    fr = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
    send(fr, 0, 1);
    chk_status("after_rst", 1'b0, 1'b1, 1'b0, 2'd0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
